wb_uart_fifo: RTL and testbench
===============================

# wb_uart_fifo

Parametrised Wishbone UART with full-duplex TX and RX, each buffered by a FIFO, and a sticky status/error register. It sits on the SoC Wishbone bus as a byte-wide slave and replaces the single-shot TX-only UART controller. It generates its own bit timing from the system clock with a compile-time divisor, so no separate clock domain is needed.

## Interface
- CLK_DIV, 16: system clocks per UART bit; must be ≥ 4. Counter width is $clog2(CLK_DIV).
- FIFO_AW, 4: FIFO address width; each FIFO holds 2**FIFO_AW bytes.
- clk  in  1  system clock; all logic is in this single domain.
- reset  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  2  register select: 0 = TXDATA, 1 = RXDATA, 2 = STATUS, 3 = reserved.
- i_wb_data  in  8  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stl  out  1  stall; tied to 0.
- o_wb_data  out  8  read data; valid when o_wb_ack is high.
- i_uart_rx  in  1  serial input; asynchronous.
- o_uart_tx  out  1  serial output; idle high.
- o_irq  out  1  level interrupt = !rx_empty | rx_overrun | frame_err.

## Operation
- **Bus access.** A request is accepted on any cycle where i_wb_cyc & i_wb_stb are both high. Side effects (push, pop, clear) take effect in that same cycle.
- **TXDATA write.**
  - Pushes i_wb_data into the TX FIFO.
  - If the FIFO is full, the byte is dropped and tx_overflow is set.
- **TXDATA read.** Returns 0x00.
- **RXDATA read.**
  - Returns the RX FIFO head and pops it.
  - If the FIFO is empty, returns 0x00 and nothing is popped.
- **RXDATA write.** Ignored.
- **STATUS read.** Bit layout:
  - [0] tx_empty
  - [1] tx_full
  - [2] rx_empty
  - [3] rx_full
  - [4] rx_overrun (sticky)
  - [5] frame_err (sticky)
  - [6] tx_busy = shifter active | !tx_empty
  - [7] tx_overflow (sticky)
- **STATUS write.** Write-1-to-clear on bits 4, 5 and 7. All other bits are ignored.
- **Address 3.** Reads return 0x00; writes are ignored.
- **FIFOs.**
  - Circular buffers with FIFO_AW-bit pointers plus one extra wrap bit.
  - full = (pointers equal, wrap bits differ). empty = (pointers and wrap bits equal).
  - Push and pop in the same cycle are both performed, including when the FIFO is full or empty (when empty, only the push is performed).
- **TX state machine (IDLE → START → DATA → STOP).**
  - In IDLE with the TX FIFO non-empty: pop the FIFO, load the shifter, enter START.
  - Each state lasts CLK_DIV cycles. DATA sends 8 bits, LSB first.
  - At the end of STOP, if the FIFO is non-empty, go directly to START with no idle gap; otherwise go to IDLE.
  - o_uart_tx is registered.
- **RX state machine (IDLE → START → DATA → STOP).**
  - i_uart_rx passes through a 2-flop synchronizer.
  - IDLE: a low on the synchronized line enters START.
  - START: wait CLK_DIV/2 cycles, then sample. If high (glitch), return to IDLE. If low, enter DATA.
  - DATA: sample every CLK_DIV cycles, 8 bits, LSB first.
  - STOP: sample the stop bit after CLK_DIV cycles.
    - Stop = 1: push the byte into the RX FIFO. If the FIFO is full and no pop happens in the same cycle, drop the byte and set rx_overrun.
    - Stop = 0: discard the byte, set frame_err, and stay in STOP until the line is high, then go to IDLE.

## Timing
- Ack latency: o_wb_ack is asserted exactly one cycle after an accepted request, for one cycle. Back-to-back requests produce back-to-back acks.
- o_wb_data is registered and presented with the ack. Data reflects the state at the request cycle.
- TX start latency: o_uart_tx falls 2 cycles after a write to TXDATA with an idle shifter (FIFO push cycle, then IDLE pop cycle). Frame length is 10·CLK_DIV cycles.
- RX latency:
  - Synchronizer delay: 2 cycles.
  - The byte becomes readable 1 cycle after the stop-bit sample, which occurs 9.5·CLK_DIV cycles after the start edge reaches the synchronizer output.
- Reset values:
  - Outputs: o_uart_tx = 1, o_wb_ack = 0, o_wb_data = 0x00, o_irq = 0.
  - Internal state: both FIFOs empty, all sticky bits 0, both FSMs in IDLE.
  - Synchronizer flops reset to 1.
- Reset mid-frame: the frame is aborted. o_uart_tx is high on the cycle after reset is sampled, and any partial RX byte is lost.
- A sticky-bit set and a W1C clear in the same cycle: the set wins.

## Test plan
- **Reset:** assert reset mid-TX-frame → o_uart_tx = 1 on the next cycle; STATUS reads 0x05.
- **TX loopback:** CLK_DIV=16. Write 0xA5 → tx low at cycle +2. Bits sampled mid-bit read 1,0,1,0,0,1,0,1 LSB-first, then stop = 1. Line idles after 160 cycles.
- **TX burst:** write 17 bytes with FIFO_AW=4.
  - The first byte moves to the shifter, so 16 remain queued and none are dropped.
  - An 18th write sets STATUS[7].
  - Frames are sent with no idle gap between them.
- **RX:** drive 0x3C serially at CLK_DIV rate.
  - rx_empty clears and o_irq rises.
  - RXDATA read returns 0x3C with ack one cycle later; rx_empty is set again afterwards.
- **RX errors:**
  - 1-cycle low glitch → no byte is received.
  - Stop bit driven 0 → frame_err = 1.
  - 17 bytes sent without reads → rx_overrun = 1 and the FIFO holds the first 16 bytes.
  - Writing 0x30 to STATUS clears both bits.
- **Empty-read / address 3:** RXDATA read with the FIFO empty returns 0x00. Write to address 3 is ignored. STATUS is unchanged except for normal status updates.

Source files
------------

// File: rtl/wb_uart_fifo.sv
// Wishbone byte-wide UART with TX/RX FIFOs and sticky status/error flags.
// Bit timing comes from a fixed system-clock divisor (CLK_DIV clocks per bit).
module wb_uart_fifo #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [1:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stl,
  output logic [7:0] o_wb_data,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic       o_irq
);

  localparam int CW    = $clog2(CLK_DIV);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic req, tx_wr, rx_rd, st_wr;
  assign req   = i_wb_cyc & i_wb_stb;
  assign tx_wr = req & i_wb_we & (i_wb_addr == 2'd0);
  assign st_wr = req & i_wb_we & (i_wb_addr == 2'd2);
  assign rx_rd = req & ~i_wb_we & (i_wb_addr == 2'd1);
  assign o_wb_stl = 1'b0;

  // FIFOs: FIFO_AW-bit index plus a wrap bit distinguishes full from empty
  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]       tx_head, rx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]) && (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]) && (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]);
  assign tx_head  = tx_mem[tx_rp[FIFO_AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[FIFO_AW-1:0]];

  uart_state_t     tx_state, rx_state;
  logic [CW-1:0]   tx_cnt, rx_cnt;
  logic [2:0]      tx_bit, rx_bit;
  logic [7:0]      tx_sh, rx_sh;
  logic            tx_cnt_end, rx_cnt_end;
  logic            rx_s1, rx_s2, rx_brk;
  logic            rx_stop_smp, rx_push_req, ferr_set;
  logic            tx_overflow, rx_overrun, frame_err, tx_busy;

  assign tx_cnt_end = (tx_cnt == BIT_LAST);
  assign rx_cnt_end = (rx_cnt == BIT_LAST);
  assign tx_pop  = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_cnt_end));
  assign tx_push = tx_wr & (~tx_full | tx_pop);
  assign rx_pop  = rx_rd & ~rx_empty;
  assign rx_stop_smp = (rx_state == S_STOP) & ~rx_brk & rx_cnt_end;
  assign rx_push_req = rx_stop_smp & rx_s2;
  assign ferr_set    = rx_stop_smp & ~rx_s2;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign tx_busy     = (tx_state != S_IDLE) | ~tx_empty;
  assign o_irq       = ~rx_empty | rx_overrun | frame_err;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= i_wb_data;
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
      tx_overflow <= 1'b0; rx_overrun <= 1'b0; frame_err <= 1'b0;
      o_wb_ack <= 1'b0; o_wb_data <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      tx_overflow <= (tx_overflow & ~(st_wr & i_wb_data[7])) | (tx_wr & tx_full & ~tx_pop);
      rx_overrun  <= (rx_overrun  & ~(st_wr & i_wb_data[4])) | (rx_push_req & rx_full & ~rx_pop);
      frame_err   <= (frame_err   & ~(st_wr & i_wb_data[5])) | ferr_set;
      o_wb_ack  <= req;
      o_wb_data <= '0;
      if (req && !i_wb_we) begin
        case (i_wb_addr)
          2'd1:    o_wb_data <= rx_empty ? 8'h00 : rx_head;
          2'd2:    o_wb_data <= {tx_overflow, tx_busy, frame_err, rx_overrun,
                                 rx_full, rx_empty, tx_full, tx_empty};
          default: o_wb_data <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0; o_uart_tx <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          o_uart_tx <= 1'b1;
          if (!tx_empty) begin
            tx_sh <= tx_head; tx_cnt <= '0; o_uart_tx <= 1'b0; tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_end) begin
            tx_cnt <= '0; tx_bit <= '0; o_uart_tx <= tx_sh[0]; tx_state <= S_DATA;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        S_DATA: begin
          if (tx_cnt_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              o_uart_tx <= 1'b1; tx_state <= S_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1; tx_sh <= tx_sh >> 1; o_uart_tx <= tx_sh[1];
            end
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        S_STOP: begin
          if (tx_cnt_end) begin
            tx_cnt <= '0;
            if (!tx_empty) begin
              tx_sh <= tx_head; o_uart_tx <= 1'b0; tx_state <= S_START;
            end else tx_state <= S_IDLE;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
      endcase
    end
  end

  // rx_brk holds STOP after a framing error until the line returns high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_state <= S_IDLE;
      rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; rx_brk <= 1'b0;
    end else begin
      rx_s1 <= i_uart_rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        S_IDLE: begin
          rx_brk <= 1'b0;
          if (!rx_s2) begin
            rx_cnt <= '0; rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0; rx_bit <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        S_DATA: begin
          if (rx_cnt_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        S_STOP: begin
          if (rx_brk) begin
            if (rx_s2) begin
              rx_brk <= 1'b0; rx_state <= S_IDLE;
            end
          end else if (rx_cnt_end) begin
            rx_cnt <= '0;
            if (rx_s2) rx_state <= S_IDLE;
            else rx_brk <= 1'b1;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed bench for wb_uart_fifo: bus registers, TX framing/burst, RX framing and errors.
module tb_wb_uart_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       uart_rx = 1'b1;
  logic       ack, stl, uart_tx, irq;
  logic [7:0] rdata;
  int         cycle = 0;
  int         n_pass = 0;
  int         n_total = 0;
  int         t1;
  logic [7:0] bv;

  wb_uart_fifo #(.CLK_DIV(16), .FIFO_AW(4)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack), .o_wb_stl(stl), .o_wb_data(rdata),
    .i_uart_rx(uart_rx), .o_uart_tx(uart_tx), .o_irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cycle < t) @(negedge clk);
  endtask

  task automatic wb(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack", 8'(ack), 8'd1);
    q = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb(1'b0, a, 8'h00, q);
    check(tag, q, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    wait_neg(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_neg(16);
    end
    uart_rx = stop;
    wait_neg(16);
    uart_rx = 1'b1;
  endtask

  initial begin
    wait_neg(3);
    reset = 1'b0;
    check("rst_tx", 8'(uart_tx), 8'd1);
    check("rst_ack", 8'(ack), 8'd0);
    check("rst_data", rdata, 8'h00);
    check("rst_irq", 8'(irq), 8'd0);
    check("rst_stall", 8'(stl), 8'd0);
    rd_chk("rst_status", 2'd2, 8'h05);

    // single TX frame of 0xA5
    bv = 8'hA5;
    wr(2'd0, bv);
    check("tx_push_cycle", 8'(uart_tx), 8'd1);
    wait_neg(1);
    t1 = cycle;
    check("tx_start_edge", 8'(uart_tx), 8'd0);
    check("ack_one_cycle", 8'(ack), 8'd0);
    wait_until(t1 + 8);
    check("tx_start_mid", 8'(uart_tx), 8'd0);
    for (int k = 1; k <= 8; k++) begin
      wait_until(t1 + 16 * k + 8);
      check("tx_bit", 8'(uart_tx), 8'(bv[k-1]));
    end
    wait_until(t1 + 152);
    check("tx_stop", 8'(uart_tx), 8'd1);
    wait_until(t1 + 160);
    check("tx_idle", 8'(uart_tx), 8'd1);
    rd_chk("tx_done_status", 2'd2, 8'h05);

    // 17-byte burst, then an 18th that overflows
    for (int i = 0; i < 17; i++) begin
      wr(2'd0, 8'(16 + i));
      if (i == 0) t1 = cycle + 1;
    end
    rd_chk("burst_full_status", 2'd2, 8'h46);
    wr(2'd0, 8'hEE);
    rd_chk("burst_ovf_status", 2'd2, 8'hC6);
    wr(2'd2, 8'h80);
    rd_chk("ovf_clear_status", 2'd2, 8'h46);
    for (int j = 0; j < 17; j++) begin
      wait_until(t1 + 160 * j + 8);
      check("burst_start", 8'(uart_tx), 8'd0);
    end
    bv = 8'h20;
    for (int k = 1; k <= 8; k++) begin
      wait_until(t1 + 160 * 16 + 16 * k + 8);
      check("burst_last_bit", 8'(uart_tx), 8'(bv[k-1]));
    end
    wait_until(t1 + 160 * 17 + 8);
    check("burst_end_idle", 8'(uart_tx), 8'd1);
    rd_chk("burst_done_status", 2'd2, 8'h05);

    // RX single byte
    send_byte(8'h3C, 1'b1);
    check("rx_irq", 8'(irq), 8'd1);
    rd_chk("rx_status", 2'd2, 8'h01);
    rd_chk("rx_data", 2'd1, 8'h3C);
    rd_chk("rx_drained_status", 2'd2, 8'h05);
    check("rx_irq_clear", 8'(irq), 8'd0);

    // one-cycle glitch
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    wait_neg(200);
    rd_chk("glitch_status", 2'd2, 8'h05);

    // framing error
    send_byte(8'h55, 1'b0);
    wait_neg(4);
    rd_chk("ferr_status", 2'd2, 8'h25);
    check("ferr_irq", 8'(irq), 8'd1);

    // overrun: 17 bytes without reading
    for (int i = 0; i < 17; i++) send_byte(8'(128 + i), 1'b1);
    rd_chk("overrun_status", 2'd2, 8'h39);
    wr(2'd2, 8'h30);
    rd_chk("w1c_status", 2'd2, 8'h09);
    for (int i = 0; i < 16; i++) rd_chk("rx_fifo_data", 2'd1, 8'(128 + i));
    rd_chk("rx_empty_status", 2'd2, 8'h05);
    rd_chk("rx_empty_read", 2'd1, 8'h00);
    rd_chk("empty_read_status", 2'd2, 8'h05);

    // ignored writes and zero reads
    wr(2'd3, 8'hFF);
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h4F);
    rd_chk("ignored_wr_status", 2'd2, 8'h05);
    rd_chk("addr3_read", 2'd3, 8'h00);
    rd_chk("txdata_read", 2'd0, 8'h00);

    // reset in the middle of a TX frame
    wr(2'd0, 8'h00);
    wait_neg(40);
    check("midframe_tx", 8'(uart_tx), 8'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_abort_tx", 8'(uart_tx), 8'd1);
    wait_neg(20);
    check("reset_stays_idle", 8'(uart_tx), 8'd1);
    rd_chk("reset_status", 2'd2, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
